// File: rtl/decoder_scan_sequencer_if.sv
// Control/status bundle between a scan controller and the decoder scan sequencer.
// The controller side drives the scan request and settings; the sequencer side drives the decoder and status.
interface decoder_scan_sequencer_if #(
   parameter int DWELL_W = 8,
   parameter int BLANK_W = 4
);
   logic               start;
   logic               stop;
   logic               cont;
   logic [7:0]         mask;
   logic [DWELL_W-1:0] dwell;
   logic [BLANK_W-1:0] blank;
   logic               A;
   logic               B;
   logic               C;
   logic               en;
   logic               busy;
   logic               frame_done;

   modport master (
      output start, stop, cont, mask, dwell, blank,
      input  A, B, C, en, busy, frame_done
   );

   modport slave (
      input  start, stop, cont, mask, dwell, blank,
      output A, B, C, en, busy, frame_done
   );
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Scans the masked channels of a 3-to-8 decoder in ascending order.
// Each channel gets an optional en-low blanking gap, then an en-high dwell.
module decoder_scan_sequencer #(
   parameter int DWELL_W = 8,
   parameter int BLANK_W = 4
) (
   input logic                    clk,
   input logic                    rst,
   decoder_scan_sequencer_if.slave bus
);
   localparam int CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

   typedef enum logic [1:0] {IDLE, BLANK, DWELL} state_t;

   state_t             state_q, state_d;
   logic [2:0]         sel_q, sel_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         mask_q, mask_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [BLANK_W-1:0] blank_q, blank_d;
   logic               en_q, en_d;
   logic               busy_q, busy_d;
   logic               fd_q, fd_d;
   logic               launch;
   logic [BLANK_W-1:0] l_blank;
   logic [DWELL_W-1:0] l_dwell;
   logic [3:0]         nxt;

   function automatic logic [2:0] lowest(input logic [7:0] m);
      logic [2:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) r = 3'(i);
      return r;
   endfunction

   // {found, index} of the next set bit strictly above cur; no wrap.
   function automatic logic [3:0] next_ch(input logic [7:0] m, input logic [2:0] cur);
      logic [3:0] r;
      r = '0;
      for (int i = 7; i >= 0; i--)
         if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
      return r;
   endfunction

   // Counter holds cycles remaining minus one; dwell 0 behaves as 1.
   function automatic logic [CNT_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
      return (d == '0) ? '0 : CNT_W'(d) - CNT_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      dwell_d = dwell_q;
      blank_d = blank_q;
      fd_d    = 1'b0;
      launch  = 1'b0;
      l_blank = blank_q;
      l_dwell = dwell_q;
      nxt     = next_ch(mask_q, sel_q);
      if (bus.stop) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start && (bus.mask != '0)) begin
                  mask_d  = bus.mask;
                  dwell_d = bus.dwell;
                  blank_d = bus.blank;
                  sel_d   = lowest(bus.mask);
                  launch  = 1'b1;
                  l_blank = bus.blank;
                  l_dwell = bus.dwell;
               end
            end
            BLANK: begin
               if (cnt_q == '0) begin
                  state_d = DWELL;
                  cnt_d   = dwell_load(dwell_q);
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            DWELL: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (nxt[3]) begin
                  sel_d  = nxt[2:0];
                  launch = 1'b1;
               end else begin
                  // End of frame: continuous mode re-reads the settings here.
                  fd_d    = 1'b1;
                  state_d = IDLE;
                  cnt_d   = '0;
                  if (bus.cont) begin
                     mask_d  = bus.mask;
                     dwell_d = bus.dwell;
                     blank_d = bus.blank;
                     if (bus.mask != '0) begin
                        sel_d   = lowest(bus.mask);
                        launch  = 1'b1;
                        l_blank = bus.blank;
                        l_dwell = bus.dwell;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
         if (launch) begin
            if (l_blank != '0) begin
               state_d = BLANK;
               cnt_d   = CNT_W'(l_blank) - CNT_W'(1);
            end else begin
               state_d = DWELL;
               cnt_d   = dwell_load(l_dwell);
            end
         end
      end
   end

   always_comb begin
      en_d   = (state_d == DWELL);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q   <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         dwell_q <= '0;
         blank_q <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         dwell_q <= dwell_d;
         blank_q <= blank_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         fd_q    <= fd_d;
      end
   end

   assign bus.A          = sel_q[2];
   assign bus.B          = sel_q[1];
   assign bus.C          = sel_q[0];
   assign bus.en         = en_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench: per-cycle expected trace is unrolled from the scan rules
// (blank cycles then dwell cycles per set mask bit) and compared every cycle.
module tb_decoder_scan_sequencer;
   logic clk;
   logic rst;

   decoder_scan_sequencer_if #(.DWELL_W(8), .BLANK_W(4)) bus ();

   decoder_scan_sequencer #(.DWELL_W(8), .BLANK_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       en;
      logic       busy;
      logic       fd;
      logic [2:0] sel;
   } exp_t;

   exp_t       exp_q[$];
   int         rd;
   logic [2:0] idle_sel;
   int         n_cmp, n_bad;
   int         en_hi, active_hits;
   logic       s_en, s_busy, s_fd;
   logic [2:0] s_sel;

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input logic e, input logic b, input logic f, input logic [2:0] s);
      exp_t x;
      x.en = e; x.busy = b; x.fd = f; x.sel = s;
      exp_q.push_back(x);
   endtask

   // One frame: for every set mask bit ascending, b blank cycles then max(d,1) dwell cycles.
   task automatic add_frame(input logic [7:0] m, input int d, input int b, input bit fd_first);
      bit first;
      int de;
      first = fd_first;
      de = (d == 0) ? 1 : d;
      for (int i = 0; i < 8; i++) begin
         if (m[i]) begin
            for (int k = 0; k < b; k++) begin push(1'b0, 1'b1, first, 3'(i)); first = 0; end
            for (int k = 0; k < de; k++) begin push(1'b1, 1'b1, first, 3'(i)); first = 0; end
            idle_sel = 3'(i);
         end
      end
   endtask

   task automatic add_end();
      push(1'b0, 1'b0, 1'b1, idle_sel);
   endtask

   task automatic flush(input logic [2:0] s);
      rd = exp_q.size();
      idle_sel = s;
   endtask

   // The per-cycle compare: sample on the falling edge, return just after the next rising edge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (rd < exp_q.size()) begin
         e = exp_q[rd];
         rd++;
      end else begin
         e.en = 1'b0; e.busy = 1'b0; e.fd = 1'b0; e.sel = idle_sel;
      end
      s_en   = bus.en;
      s_busy = bus.busy;
      s_fd   = bus.frame_done;
      s_sel  = {bus.A, bus.B, bus.C};
      chk("en", s_en, e.en);
      chk("busy", s_busy, e.busy);
      chk("frame_done", s_fd, e.fd);
      chk("sel", s_sel, e.sel);
      if (s_en) en_hi++;
      if (s_en || s_busy || s_fd) active_hits++;
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic start_pulse();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   task automatic setup(input logic [7:0] m, input logic [7:0] d, input logic [3:0] b, input logic c);
      bus.mask = m; bus.dwell = d; bus.blank = b; bus.cont = c;
   endtask

   task automatic scenario1();
      setup(8'hFF, 8'd2, 4'd0, 1'b0);
      start_pulse();
      add_frame(8'hFF, 2, 0, 0);
      add_end();
      chk("t1_model_len", exp_q.size() - rd, 17);
      en_hi = 0;
      steps(16);
      chk("t1_en_cycles", en_hi, 16);
      step();
      chk("t1_done_pulse", s_fd, 1);
      chk("t1_busy_at_done", s_busy, 0);
      chk("t1_sel_at_done", s_sel, 7);
      steps(2);
   endtask

   int t2_en[7]  = '{0, 1, 0, 1, 0, 1, 0};
   int t2_sel[7] = '{2, 2, 5, 5, 7, 7, 7};

   initial begin
      n_cmp = 0; n_bad = 0; rd = 0; idle_sel = 3'd0;
      en_hi = 0; active_hits = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.stop = 1'b0;
      setup(8'h00, 8'd0, 4'd0, 1'b0);
      #3;
      chk("reset_sel", {bus.A, bus.B, bus.C}, 0);
      chk("reset_en", bus.en, 0);
      chk("reset_busy", bus.busy, 0);
      chk("reset_frame_done", bus.frame_done, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      steps(2);

      // 1: full mask, back-to-back channels with no gap
      scenario1();

      // 2: sparse mask with single-cycle blank and dwell
      setup(8'b1010_0100, 8'd1, 4'd1, 1'b0);
      start_pulse();
      add_frame(8'b1010_0100, 1, 1, 0);
      add_end();
      for (int i = 0; i < 7; i++) begin
         step();
         chk("t2_en_lit", s_en, t2_en[i]);
         chk("t2_sel_lit", s_sel, t2_sel[i]);
      end
      chk("t2_done_lit", s_fd, 1);
      steps(2);

      // 3: empty mask is ignored; dwell 0 acts as one cycle
      setup(8'h00, 8'd3, 4'd0, 1'b0);
      active_hits = 0;
      start_pulse();
      steps(20);
      chk("t3_quiet", active_hits, 0);
      setup(8'h01, 8'd0, 4'd0, 1'b0);
      start_pulse();
      add_frame(8'h01, 0, 0, 0);
      add_end();
      en_hi = 0;
      steps(4);
      chk("t3_dwell0_cycles", en_hi, 1);

      // 4: continuous mode, mask change mid-frame applies at the next frame
      setup(8'h0F, 8'd2, 4'd1, 1'b1);
      start_pulse();
      add_frame(8'h0F, 2, 1, 0);
      steps(4);
      bus.mask = 8'h30;
      add_frame(8'h30, 2, 1, 1);
      steps(8);
      step();
      chk("t4_second_frame_done", s_fd, 1);
      chk("t4_second_frame_sel", s_sel, 4);
      step();
      bus.cont = 1'b0;
      add_end();
      steps(8);

      // 5: stop (with start) in third dwell cycle aborts without frame_done
      setup(8'b0001_1000, 8'd5, 4'd0, 1'b0);
      start_pulse();
      add_frame(8'b0001_1000, 5, 0, 0);
      add_end();
      steps(2);
      bus.stop = 1'b1; bus.start = 1'b1;
      step();
      bus.stop = 1'b0; bus.start = 1'b0;
      flush(3'd3);
      active_hits = 0;
      steps(5);
      chk("t5_stopped", active_hits, 0);
      start_pulse();
      add_frame(8'b0001_1000, 5, 0, 0);
      add_end();
      step();
      chk("t5_restart_sel", s_sel, 3);
      chk("t5_restart_en", s_en, 1);
      steps(12);

      // 6: asynchronous reset mid-dwell, then a normal frame
      setup(8'hFF, 8'd2, 4'd0, 1'b0);
      start_pulse();
      add_frame(8'hFF, 2, 0, 0);
      add_end();
      steps(5);
      #1 rst = 1'b1;
      #1;
      chk("t6_async_sel", {bus.A, bus.B, bus.C}, 0);
      chk("t6_async_en", bus.en, 0);
      chk("t6_async_busy", bus.busy, 0);
      chk("t6_async_frame_done", bus.frame_done, 0);
      flush(3'd0);
      #1 rst = 1'b0;
      steps(3);
      scenario1();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
